rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Arbitrates the single register-file write port between two writeback requesters.
  - Requester 0: ALU/execute, the default-priority port.
  - Requester 1: load/store unit, which returns late.
- Registers the winning write and drives it to the register file's RegWrite / write_reg / write_data.
- A starvation counter with a two-state FSM guarantees forward progress for requester 1.
- Sits between the execute/memory stages and the 32x32 register file.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles requester 1 may be stalled before it is promoted.
- CNT_W, 3: starvation counter width; must hold STARVE_LIMIT.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset: asynchronous, active-low.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  5  destination register of requester 0.
- req0_data  in  32  write data of requester 0.
- req0_ready  out  1  requester 0 granted this cycle.
- req1_valid  in  1  requester 1 has a write pending.
- req1_addr  in  5  destination register of requester 1.
- req1_data  in  32  write data of requester 1.
- req1_ready  out  1  requester 1 granted this cycle.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  register-file write address (registered).
- rf_wdata  out  32  register-file write data (registered).
- starved  out  1  high while the FSM is in BOOST.

Behaviour:
- Handshake and transfer:
  - reqN_ready is combinational from the current state and the valids.
  - A transfer occurs when valid && ready on the rising edge.
  - A requester must hold valid, addr and data stable until accepted.
  - At most one ready is high per cycle.
- FSM states:
  - NORMAL: requester 0 wins whenever req0_valid=1; requester 1 wins only when req0_valid=0.
  - BOOST: requester 1 wins whenever req1_valid=1; requester 0 wins only when req1_valid=0.
- Starvation counter cnt:
  - In NORMAL, cnt increments (saturating) each cycle with req1_valid=1 and req1_ready=0.
  - cnt clears on any req1 transfer, or when req1_valid=0.
- Transitions:
  - NORMAL -> BOOST when cnt == STARVE_LIMIT-1 and the stall condition holds in that cycle. BOOST takes effect next cycle.
  - BOOST -> NORMAL after a req1 transfer, or if req1_valid drops; cnt clears.
  - BOOST never lasts more than one accepted req1 write.
- Output registers, updated every cycle:
  - rf_we <= (a transfer occurred) && (winning addr != 0).
  - rf_waddr/rf_wdata <= winning addr/data.
  - When idle, rf_we <= 0 and addr/data hold their previous values.
  - Latency: exactly one cycle from acceptance to the rf_we pulse.
- x0 destination: the write is accepted (ready=1) but rf_we stays 0; it still counts as a req1 transfer for the counter.
- Reset:
  - rf_we=0, rf_waddr=0, rf_wdata=0, state=NORMAL, cnt=0, starved=0.
  - Ready outputs go low while RST_N=0.
  - Asserting reset mid-BOOST or mid-transfer drops the in-flight write; no rf_we pulse is produced after reset release.
- Simultaneous writes to the same addr from both requesters: only the winner is written. The loser is written in a later cycle, so the final value reflects arbitration order.

Optional Feature:
- Macro RF_WB_ARB_BYPASS_EN.
- When defined, add read-bypass ports:
  - Inputs: rd_addr1/rd_addr2 (5), rf_rdata1/rf_rdata2 (32).
  - Outputs: rd_data1/rd_data2 (32).
- With the macro, rd_dataK = rf_wdata when rf_we && rf_waddr == rd_addrK && rd_addrK != 0; otherwise rd_dataK = rf_rdataK.
  - This gives same-cycle forwarding of the write being committed to the register file.
- Without the macro, these ports do not exist and the core reads the register file directly.

Decomposition:
- Shared package rf_pkg:
  - Constants: RF_ADDR_W=5, RF_DATA_W=32, RF_ZERO_REG=5'd0.
  - typedef wb_req_t {addr, data}.
  - typedef enum arb_state_e {NORMAL, BOOST}.
- One natural sub-module: rf_starve_ctr (counter plus compare, outputs promote).
- Arbitration mux and output registers stay in the top.

Test Plan:
- Only req0_valid=1, addr=5, data=0xDEADBEEF → req0_ready=1 in the same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
- Both valid continuously with STARVE_LIMIT=4:
  - req0 is granted cycles 0-3.
  - starved=1 from cycle 4; req1 is granted in cycle 4.
  - The FSM returns to NORMAL in cycle 5.
- req1_valid=1, addr=0, data=0x1234 → req1_ready=1; rf_we stays 0; cnt clears.
- Reset asserted during BOOST with a pending req1 → all outputs 0 immediately; after release the state is NORMAL; no spurious rf_we.
- Both requesters target addr=7 (0xAAAA from req0, 0x5555 from req1) → rf_we pulses twice in order: 0xAAAA first, then 0x5555.
- With RF_WB_ARB_BYPASS_EN: rf_we=1, rf_waddr=3, rd_addr1=3 → rd_data1=rf_wdata. With rd_addr1=0 → rd_data1=rf_rdata1.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_pkg;

    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_DATA_W = 32;
    localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = 5'd0;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [0:0] {NORMAL, BOOST} arb_state_e;

    function automatic logic is_zero_reg(input logic [RF_ADDR_W-1:0] addr);
        return addr == RF_ZERO_REG;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bus: two requesters in, registered RF write port out.
// Bypass signals exist only when RF_WB_ARB_BYPASS_EN is defined.
interface rf_wb_arbiter_if;
    import rf_pkg::*;

    logic                 req0_valid;
    logic [RF_ADDR_W-1:0] req0_addr;
    logic [RF_DATA_W-1:0] req0_data;
    logic                 req0_ready;
    logic                 req1_valid;
    logic [RF_ADDR_W-1:0] req1_addr;
    logic [RF_DATA_W-1:0] req1_data;
    logic                 req1_ready;
    logic                 rf_we;
    logic [RF_ADDR_W-1:0] rf_waddr;
    logic [RF_DATA_W-1:0] rf_wdata;
    logic                 starved;
`ifdef RF_WB_ARB_BYPASS_EN
    logic [RF_ADDR_W-1:0] rd_addr1;
    logic [RF_ADDR_W-1:0] rd_addr2;
    logic [RF_DATA_W-1:0] rf_rdata1;
    logic [RF_DATA_W-1:0] rf_rdata2;
    logic [RF_DATA_W-1:0] rd_data1;
    logic [RF_DATA_W-1:0] rd_data2;
`endif

    modport master (
        output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
`ifdef RF_WB_ARB_BYPASS_EN
        output rd_addr1, rd_addr2, rf_rdata1, rf_rdata2,
        input  rd_data1, rd_data2,
`endif
        input  req0_ready, req1_ready, rf_we, rf_waddr, rf_wdata, starved
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
`ifdef RF_WB_ARB_BYPASS_EN
        input  rd_addr1, rd_addr2, rf_rdata1, rf_rdata2,
        output rd_data1, rd_data2,
`endif
        output req0_ready, req1_ready, rf_we, rf_waddr, rf_wdata, starved
    );

endinterface

// File: rtl/rf_starve_ctr.sv
// Counts consecutive stalled cycles of requester 1 and flags promotion to BOOST.
module rf_starve_ctr #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic i_normal,
    input  logic i_req1_valid,
    input  logic i_req1_ready,
    output logic o_promote
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_stall;

    assign w_stall   = i_req1_valid & ~i_req1_ready;
    assign o_promote = i_normal & w_stall & (r_cnt == CNT_W'(STARVE_LIMIT - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else if (!i_req1_valid || i_req1_ready) begin
            r_cnt <= '0;
        end else if (i_normal && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester writeback arbiter for the RF write port with starvation boost.
// Optional same-cycle read bypass under RF_WB_ARB_BYPASS_EN.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic            CLK,
    input  logic            RST_N,
    rf_wb_arbiter_if.slave  bus
);

    arb_state_e           r_state;
    logic                 r_rf_we;
    logic [RF_ADDR_W-1:0] r_rf_waddr;
    logic [RF_DATA_W-1:0] r_rf_wdata;
    logic                 w_ready0;
    logic                 w_ready1;
    logic                 w_xfer;
    logic                 w_promote;
    wb_req_t              w_win;

    // Readies are forced low while in reset so nothing is accepted then.
    always_comb begin
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        if (RST_N) begin
            if (r_state == BOOST) begin
                w_ready1 = bus.req1_valid;
                w_ready0 = bus.req0_valid & ~bus.req1_valid;
            end else begin
                w_ready0 = bus.req0_valid;
                w_ready1 = bus.req1_valid & ~bus.req0_valid;
            end
        end
    end

    assign w_xfer = w_ready0 | w_ready1;
    assign w_win  = w_ready1 ? wb_req_t'{addr: bus.req1_addr, data: bus.req1_data}
                             : wb_req_t'{addr: bus.req0_addr, data: bus.req0_data};

    rf_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve_ctr (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .i_normal     (r_state == NORMAL),
        .i_req1_valid (bus.req1_valid),
        .i_req1_ready (w_ready1),
        .o_promote    (w_promote)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= NORMAL;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_xfer && !is_zero_reg(w_win.addr);
            if (w_xfer) begin
                r_rf_waddr <= w_win.addr;
                r_rf_wdata <= w_win.data;
            end
            unique case (r_state)
                NORMAL:  if (w_promote) r_state <= BOOST;
                BOOST:   if (!bus.req1_valid || w_ready1) r_state <= NORMAL;
                default: r_state <= NORMAL;
            endcase
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.rf_we      = r_rf_we;
    assign bus.rf_waddr   = r_rf_waddr;
    assign bus.rf_wdata   = r_rf_wdata;
    assign bus.starved    = (r_state == BOOST);

`ifdef RF_WB_ARB_BYPASS_EN
    // Forward the write being committed this cycle to the read ports.
    assign bus.rd_data1 = (r_rf_we && (r_rf_waddr == bus.rd_addr1) && !is_zero_reg(bus.rd_addr1))
                          ? r_rf_wdata : bus.rf_rdata1;
    assign bus.rd_data2 = (r_rf_we && (r_rf_waddr == bus.rd_addr2) && !is_zero_reg(bus.rd_addr2))
                          ? r_rf_wdata : bus.rf_rdata2;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: expected RF writes queued at issue, checked by a monitor.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    rf_wb_arbiter_if u_if ();

    rf_wb_arbiter #(
        .STARVE_LIMIT (4),
        .CNT_W        (3)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (u_if)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t push_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Every rf_we pulse must match the oldest queued write, address, data and cycle.
    always @(negedge CLK) begin
        if (u_if.rf_we !== 1'b0) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got we=%b addr=%0d data=%h, expected no write",
                         u_if.rf_we, u_if.rf_waddr, u_if.rf_wdata);
            end else begin
                mon_e = sb.pop_front();
                if (u_if.rf_waddr !== mon_e.a || u_if.rf_wdata !== mon_e.d || cyc != mon_e.c) begin
                    bad++;
                    $display("FAIL rf_write: got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d",
                             u_if.rf_waddr, u_if.rf_wdata, cyc, mon_e.a, mon_e.d, mon_e.c);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        push_e.a = a;
        push_e.d = d;
        push_e.c = cyc + 1;
        sb.push_back(push_e);
    endtask

    // Called at posedge+1; drives one cycle, checks grants, queues the expected write.
    task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic e0, input logic e1, input logic es, input string tag);
        u_if.req0_valid = v0;
        u_if.req0_addr  = a0;
        u_if.req0_data  = d0;
        u_if.req1_valid = v1;
        u_if.req1_addr  = a1;
        u_if.req1_data  = d1;
        #1;
        chk({tag, ".ready0"}, {31'd0, u_if.req0_ready}, {31'd0, e0});
        chk({tag, ".ready1"}, {31'd0, u_if.req1_ready}, {31'd0, e1});
        chk({tag, ".starved"}, {31'd0, u_if.starved}, {31'd0, es});
        if (e0 && a0 != 5'd0) push(a0, d0);
        if (e1 && a1 != 5'd0) push(a1, d1);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input string tag);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        u_if.req0_valid = 1'b1;
        u_if.req0_addr  = 5'd1;
        u_if.req0_data  = 32'h1;
        u_if.req1_valid = 1'b1;
        u_if.req1_addr  = 5'd2;
        u_if.req1_data  = 32'h2;
`ifdef RF_WB_ARB_BYPASS_EN
        u_if.rd_addr1  = 5'd0;
        u_if.rd_addr2  = 5'd0;
        u_if.rf_rdata1 = 32'd0;
        u_if.rf_rdata2 = 32'd0;
`endif
        #2;
        chk("rst.ready0", {31'd0, u_if.req0_ready}, 32'd0);
        chk("rst.ready1", {31'd0, u_if.req1_ready}, 32'd0);
        chk("rst.we", {31'd0, u_if.rf_we}, 32'd0);
        chk("rst.waddr", {27'd0, u_if.rf_waddr}, 32'd0);
        chk("rst.wdata", u_if.rf_wdata, 32'd0);
        chk("rst.starved", {31'd0, u_if.starved}, 32'd0);
        @(posedge CLK);
        #1;
        u_if.req0_valid = 1'b0;
        u_if.req1_valid = 1'b0;
        RST_N = 1'b1;

        // Single requester 0 write, then idle holds addr/data.
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, "solo0");
        idle("solo0_idle");
        chk("hold.we", {31'd0, u_if.rf_we}, 32'd0);
        chk("hold.waddr", {27'd0, u_if.rf_waddr}, 32'd5);
        chk("hold.wdata", u_if.rf_wdata, 32'hDEADBEEF);

        // Continuous contention: req0 for 4 cycles, then boosted req1, then NORMAL.
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'(i + 1), 32'h100 + i, 1'b1, 5'd9, 32'h99, 1'b1, 1'b0, 1'b0, "cont");
        step(1'b1, 5'd10, 32'h110, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 1'b1, "cont_boost");
        step(1'b1, 5'd11, 32'h111, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, "cont_back");
        idle("cont_idle");

        // An x0 write by req1 is accepted, not written, and clears the counter.
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd12, 32'h120 + i, 1'b1, 5'd0, 32'h1234, 1'b1, 1'b0, 1'b0, "x0_stall");
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b1, 1'b0, "x0_accept");
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'd13, 32'h130 + i, 1'b1, 5'd14, 32'h140, 1'b1, 1'b0, 1'b0, "x0_recount");
        step(1'b1, 5'd13, 32'h134, 1'b1, 5'd14, 32'h140, 1'b0, 1'b1, 1'b1, "x0_boost");
        idle("x0_idle");

        // Reset while in BOOST with req1 pending.
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'd0, 32'h200 + i, 1'b1, 5'd15, 32'h150, 1'b1, 1'b0, 1'b0, "rst_stall");
        chk("rst_mid.pre_starved", {31'd0, u_if.starved}, 32'd1);
        RST_N = 1'b0;
        #1;
        chk("rst_mid.ready0", {31'd0, u_if.req0_ready}, 32'd0);
        chk("rst_mid.ready1", {31'd0, u_if.req1_ready}, 32'd0);
        chk("rst_mid.starved", {31'd0, u_if.starved}, 32'd0);
        chk("rst_mid.we", {31'd0, u_if.rf_we}, 32'd0);
        chk("rst_mid.waddr", {27'd0, u_if.rf_waddr}, 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        step(1'b1, 5'd16, 32'h160, 1'b1, 5'd15, 32'h150, 1'b1, 1'b0, 1'b0, "rst_after");
        idle("rst_after_idle");

        // Same destination from both: req0 value first, then req1 value.
        step(1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'h5555, 1'b1, 1'b0, 1'b0, "same_a");
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h5555, 1'b0, 1'b1, 1'b0, "same_b");
        idle("same_idle");

`ifdef RF_WB_ARB_BYPASS_EN
        step(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, "byp_wr");
        u_if.rf_rdata1 = 32'hFFFF;
        u_if.rd_addr1  = 5'd3;
        #1;
        chk("byp.hit", u_if.rd_data1, 32'h33);
        u_if.rd_addr1 = 5'd0;
        #1;
        chk("byp.x0", u_if.rd_data1, 32'hFFFF);
        @(posedge CLK);
        #1;
`endif

        idle("end_a");
        idle("end_b");
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
